// File: rtl/uart_arb_pkg.sv
// Shared state encodings and index helpers for the UART TX arbiter.
package uart_arb_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  // Increment a requester index with an explicit wrap at n-1, so a
  // non-power-of-two requester count never lands on an unused index.
  function automatic logic [3:0] wrap_inc(input logic [3:0] idx, input int n);
    int i;
    i = int'(idx);
    if (i >= n - 1) return 4'd0;
    return 4'(i + 1);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream handshake bundle: NUM_REQ requester lanes in, one UART TX lane out.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  // Arbiter side.
  modport slave (
    input  req_data, req_valid, req_last, tx_ready,
    output req_ready, tx_data, tx_valid
  );

  // Byte sources plus serializer side.
  modport master (
    output req_data, req_valid, req_last, tx_ready,
    input  req_ready, tx_data, tx_valid
  );
endinterface

// File: rtl/uart_rr_pick.sv
// Rotating-priority picker: lowest valid index at or after rr_ptr, wrapping.
module uart_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDW-1:0]     rr_ptr,
  output logic               any_valid,
  output logic [IDW-1:0]     winner
);
  localparam int W2 = 2 * NUM_REQ;

  logic [W2-1:0] dbl;
  logic [W2-1:0] mask;
  logic [W2-1:0] masked;

  // Lower copy keeps only bits >= rr_ptr; upper copy supplies the wrap-around.
  always_comb begin
    dbl       = {req_valid, req_valid};
    mask      = ~((W2'(1) << rr_ptr) - W2'(1));
    masked    = dbl & mask;
    any_valid = |req_valid;
    winner    = '0;
    for (int j = W2 - 1; j >= 0; j--)
      if (masked[j]) winner = IDW'(j % NUM_REQ);
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART TX byte port.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int IDW            = $clog2(NUM_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  uart_tx_arbiter_if.slave bus,
  output logic [IDW-1:0]   grant_id,
  output logic             busy,
  output logic             timeout_err
);
  localparam int CW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] T_LAST = CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  logic [1:0]     state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] owner_q, owner_d;
  logic           last_q, last_d;
  logic [7:0]     tx_data_q, tx_data_d;
  logic           tx_valid_q, tx_valid_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           timeout_err_q, timeout_err_d;
  logic           run_q;

  logic           any_valid;
  logic [IDW-1:0] winner;

  uart_rr_pick #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_pick (
    .req_valid (bus.req_valid),
    .rr_ptr    (rr_ptr_q),
    .any_valid (any_valid),
    .winner    (winner)
  );

  // Next-state, handshake and counter logic; req_ready is at most one-hot.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    owner_d       = owner_q;
    last_d        = last_q;
    tx_data_d     = tx_data_q;
    tx_valid_d    = tx_valid_q;
    cnt_d         = cnt_q;
    timeout_err_d = 1'b0;
    bus.req_ready = '0;
    case (state_q)
      ST_IDLE: begin
        if (run_q && any_valid) begin
          bus.req_ready[winner] = 1'b1;
          tx_data_d  = bus.req_data[int'(winner)*8 +: 8];
          tx_valid_d = 1'b1;
          owner_d    = winner;
          last_d     = bus.req_last[winner];
          state_d    = ST_SEND;
        end
      end
      ST_SEND: begin
        if (bus.tx_ready) begin
          tx_valid_d = 1'b0;
          if (last_q) begin
            rr_ptr_d = IDW'(wrap_inc(4'(owner_q), NUM_REQ));
            state_d  = ST_IDLE;
          end else begin
            cnt_d   = '0;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (run_q && bus.req_valid[owner_q]) begin
          bus.req_ready[owner_q] = 1'b1;
          tx_data_d  = bus.req_data[int'(owner_q)*8 +: 8];
          tx_valid_d = 1'b1;
          last_d     = bus.req_last[owner_q];
          state_d    = ST_SEND;
        end else if (TIMEOUT_CYCLES != 0 && cnt_q == T_LAST) begin
          timeout_err_d = 1'b1;
          rr_ptr_d      = IDW'(wrap_inc(4'(owner_q), NUM_REQ));
          state_d       = ST_IDLE;
        end else if (TIMEOUT_CYCLES != 0) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; async reset abandons any packet in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      rr_ptr_q      <= '0;
      owner_q       <= '0;
      last_q        <= 1'b0;
      tx_data_q     <= '0;
      tx_valid_q    <= 1'b0;
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
      run_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      owner_q       <= owner_d;
      last_q        <= last_d;
      tx_data_q     <= tx_data_d;
      tx_valid_q    <= tx_valid_d;
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
      run_q         <= 1'b1;
    end
  end

  assign bus.tx_data  = tx_data_q;
  assign bus.tx_valid = tx_valid_q;
  assign grant_id     = owner_q;
  assign busy         = (state_q != ST_IDLE);
  assign timeout_err  = timeout_err_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed vector bench for uart_tx_arbiter (4 requesters, 16-cycle timeout).
module tb_uart_tx_arbiter;

  typedef struct {
    logic [31:0] rd;
    logic [3:0]  rv;
    logic [3:0]  rl;
    logic        trdy;
    logic [3:0]  err;
    logic        etv;
    logic [7:0]  etd;
    logic        ebusy;
    logic [1:0]  egid;
    logic        eterr;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [1:0] grant_id;
  logic       busy;
  logic       timeout_err;
  int         n_vec;
  int         n_err;
  vec_t       tbl[$];

  uart_tx_arbiter_if #(.NUM_REQ(4)) bus ();

  uart_tx_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [31:0] rd, input logic [3:0] rv, input logic [3:0] rl,
                              input logic trdy, input logic [3:0] err, input logic etv,
                              input logic [7:0] etd, input logic ebusy, input logic [1:0] egid,
                              input logic eterr);
    vec_t v;
    v.rd = rd; v.rv = rv; v.rl = rl; v.trdy = trdy;
    v.err = err; v.etv = etv; v.etd = etd; v.ebusy = ebusy; v.egid = egid; v.eterr = eterr;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.req_data  = v.rd;
    bus.req_valid = v.rv;
    bus.req_last  = v.rl;
    bus.tx_ready  = v.trdy;
  endtask

  task automatic check(input string nm, input vec_t v);
    logic bad;
    n_vec++;
    bad = (bus.req_ready !== v.err) || (bus.tx_valid !== v.etv) || (bus.tx_data !== v.etd) ||
          (busy !== v.ebusy) || (timeout_err !== v.eterr) || (v.ebusy && (grant_id !== v.egid));
    if (bad) begin
      n_err++;
      $display("FAIL %s: got rdy=%b tv=%b td=%h busy=%b gid=%0d terr=%b, want rdy=%b tv=%b td=%h busy=%b gid=%0d terr=%b",
               nm, bus.req_ready, bus.tx_valid, bus.tx_data, busy, grant_id, timeout_err,
               v.err, v.etv, v.etd, v.ebusy, v.egid, v.eterr);
    end
  endtask

  task automatic apply(input string nm, input vec_t v);
    @(negedge clk);
    drive(v);
    #1;
    check(nm, v);
  endtask

  task automatic check_gid0(input string nm);
    n_vec++;
    if (grant_id !== 2'd0) begin
      n_err++;
      $display("FAIL %s: got grant_id=%0d, want 0", nm, grant_id);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;

    // single request, then rr_ptr=1 shown by picking req3 over req0
    tbl.push_back(mk(32'h000000A5, 4'b0001, 4'b0001, 1, 4'b0001, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(32'h00000000, 4'b0000, 4'b0000, 1, 4'b0000, 1, 8'hA5, 1, 0, 0));
    tbl.push_back(mk(32'h00000000, 4'b0000, 4'b0000, 1, 4'b0000, 0, 8'hA5, 0, 0, 0));
    tbl.push_back(mk(32'h03000001, 4'b1001, 4'b1001, 1, 4'b1000, 0, 8'hA5, 0, 0, 0));
    tbl.push_back(mk(32'h00000000, 4'b0000, 4'b0000, 1, 4'b0000, 1, 8'h03, 1, 3, 0));
    tbl.push_back(mk(32'h00000000, 4'b0000, 4'b0000, 1, 4'b0000, 0, 8'h03, 0, 0, 0));
    // round robin req0 / req2
    tbl.push_back(mk(32'h00200010, 4'b0101, 4'b0101, 1, 4'b0001, 0, 8'h03, 0, 0, 0));
    tbl.push_back(mk(32'h00200010, 4'b0101, 4'b0101, 1, 4'b0000, 1, 8'h10, 1, 0, 0));
    tbl.push_back(mk(32'h00200010, 4'b0101, 4'b0101, 1, 4'b0100, 0, 8'h10, 0, 0, 0));
    tbl.push_back(mk(32'h00200010, 4'b0101, 4'b0101, 1, 4'b0000, 1, 8'h20, 1, 2, 0));
    tbl.push_back(mk(32'h00200010, 4'b0101, 4'b0101, 1, 4'b0001, 0, 8'h20, 0, 0, 0));
    tbl.push_back(mk(32'h00200010, 4'b0101, 4'b0101, 1, 4'b0000, 1, 8'h10, 1, 0, 0));
    tbl.push_back(mk(32'h00200010, 4'b0101, 4'b0101, 1, 4'b0100, 0, 8'h10, 0, 0, 0));
    tbl.push_back(mk(32'h00200010, 4'b0101, 4'b0101, 1, 4'b0000, 1, 8'h20, 1, 2, 0));
    // req0 one packet to move rr_ptr to 1, then req1 3-byte packet while req0 waits
    tbl.push_back(mk(32'h00000044, 4'b0001, 4'b0001, 1, 4'b0001, 0, 8'h20, 0, 0, 0));
    tbl.push_back(mk(32'h00000044, 4'b0001, 4'b0001, 1, 4'b0000, 1, 8'h44, 1, 0, 0));
    tbl.push_back(mk(32'h00001144, 4'b0011, 4'b0001, 1, 4'b0010, 0, 8'h44, 0, 0, 0));
    tbl.push_back(mk(32'h00002244, 4'b0011, 4'b0001, 1, 4'b0000, 1, 8'h11, 1, 1, 0));
    tbl.push_back(mk(32'h00002244, 4'b0011, 4'b0001, 1, 4'b0010, 0, 8'h11, 1, 1, 0));
    tbl.push_back(mk(32'h00003344, 4'b0011, 4'b0011, 1, 4'b0000, 1, 8'h22, 1, 1, 0));
    tbl.push_back(mk(32'h00003344, 4'b0011, 4'b0011, 1, 4'b0010, 0, 8'h22, 1, 1, 0));
    tbl.push_back(mk(32'h00000044, 4'b0001, 4'b0001, 1, 4'b0000, 1, 8'h33, 1, 1, 0));
    tbl.push_back(mk(32'h00000044, 4'b0001, 4'b0001, 1, 4'b0001, 0, 8'h33, 0, 0, 0));
    tbl.push_back(mk(32'h00000000, 4'b0000, 4'b0000, 1, 4'b0000, 1, 8'h44, 1, 0, 0));
    tbl.push_back(mk(32'h00000000, 4'b0000, 4'b0000, 1, 4'b0000, 0, 8'h44, 0, 0, 0));

    // reset state and the run-flag gate on the release cycle
    rst_n = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset", mk(0, 0, 0, 0, 4'b0000, 0, 8'h00, 0, 0, 0));
    check_gid0("reset_gid");
    @(negedge clk);
    rst_n = 1'b1;
    drive(mk(32'h000000A5, 4'b0001, 4'b0001, 1, 0, 0, 0, 0, 0, 0));
    #1;
    check("run_gate", mk(32'h000000A5, 4'b0001, 4'b0001, 1, 4'b0000, 0, 8'h00, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) apply($sformatf("tbl%0d", i), tbl[i]);

    // backpressure: req2 byte 0x5C held 20 cycles, then one transfer
    apply("bp_grant", mk(32'h005C0000, 4'b0100, 4'b0100, 0, 4'b0100, 0, 8'h44, 0, 0, 0));
    for (int k = 0; k < 20; k++)
      apply($sformatf("bp_hold%0d", k), mk(32'h005C0000, 4'b0100, 4'b0100, 0, 4'b0000, 1, 8'h5C, 1, 2, 0));
    apply("bp_xfer", mk(32'h00000000, 4'b0000, 4'b0000, 1, 4'b0000, 1, 8'h5C, 1, 2, 0));
    apply("bp_done", mk(32'h00000000, 4'b0000, 4'b0000, 0, 4'b0000, 0, 8'h5C, 0, 0, 0));

    // timeout: req3 idles mid-packet, req0 pending gets the next grant
    apply("to_grant", mk(32'h77000055, 4'b1001, 4'b0001, 1, 4'b1000, 0, 8'h5C, 0, 0, 0));
    apply("to_send",  mk(32'h00000055, 4'b0001, 4'b0001, 1, 4'b0000, 1, 8'h77, 1, 3, 0));
    for (int k = 0; k < 16; k++)
      apply($sformatf("to_w%0d", k), mk(32'h00000055, 4'b0001, 4'b0001, 0, 4'b0000, 0, 8'h77, 1, 3, 0));
    apply("to_pulse", mk(32'h00000055, 4'b0001, 4'b0001, 0, 4'b0001, 0, 8'h77, 0, 0, 1));
    apply("to_req0",  mk(32'h00000000, 4'b0000, 4'b0000, 1, 4'b0000, 1, 8'h55, 1, 0, 0));
    apply("to_after", mk(32'h00000000, 4'b0000, 4'b0000, 0, 4'b0000, 0, 8'h55, 0, 0, 0));

    // revalidate exactly on the expiry cycle: byte taken, no pulse
    apply("nt_grant", mk(32'h78000000, 4'b1000, 4'b0000, 1, 4'b1000, 0, 8'h55, 0, 0, 0));
    apply("nt_send",  mk(32'h00000000, 4'b0000, 4'b0000, 1, 4'b0000, 1, 8'h78, 1, 3, 0));
    for (int k = 0; k < 15; k++)
      apply($sformatf("nt_w%0d", k), mk(32'h00000000, 4'b0000, 4'b0000, 0, 4'b0000, 0, 8'h78, 1, 3, 0));
    apply("nt_edge",  mk(32'h79000000, 4'b1000, 4'b1000, 0, 4'b1000, 0, 8'h78, 1, 3, 0));
    apply("nt_send2", mk(32'h00000000, 4'b0000, 4'b0000, 1, 4'b0000, 1, 8'h79, 1, 3, 0));
    apply("nt_idle",  mk(32'h00000000, 4'b0000, 4'b0000, 0, 4'b0000, 0, 8'h79, 0, 0, 0));

    // mid-packet reset: rr_ptr=1 before, req2 packet aborted in WAIT
    apply("mr_r0", mk(32'h00000066, 4'b0001, 4'b0001, 1, 4'b0001, 0, 8'h79, 0, 0, 0));
    apply("mr_r1", mk(32'h00000000, 4'b0000, 4'b0000, 1, 4'b0000, 1, 8'h66, 1, 0, 0));
    apply("mr_r2", mk(32'h00A10000, 4'b0100, 4'b0000, 1, 4'b0100, 0, 8'h66, 0, 0, 0));
    apply("mr_r3", mk(32'h00A20000, 4'b0100, 4'b0000, 1, 4'b0000, 1, 8'hA1, 1, 2, 0));
    apply("mr_wait", mk(32'h00000000, 4'b0000, 4'b0000, 0, 4'b0000, 0, 8'hA1, 1, 2, 0));
    @(negedge clk);
    rst_n = 1'b0;
    drive(mk(32'h00A20000, 4'b0100, 4'b0000, 1, 0, 0, 0, 0, 0, 0));
    #1;
    check("mr_abort", mk(0, 0, 0, 0, 4'b0000, 0, 8'h00, 0, 0, 0));
    check_gid0("mr_abort_gid");
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("mr_hold", mk(0, 0, 0, 0, 4'b0000, 0, 8'h00, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;
    drive(mk(32'h00A200B0, 4'b0101, 4'b0101, 1, 0, 0, 0, 0, 0, 0));
    #1;
    check("mr_gate", mk(0, 0, 0, 0, 4'b0000, 0, 8'h00, 0, 0, 0));
    apply("mr_grant", mk(32'h00A200B0, 4'b0101, 4'b0101, 1, 4'b0001, 0, 8'h00, 0, 0, 0));
    apply("mr_send",  mk(32'h00000000, 4'b0000, 4'b0000, 1, 4'b0000, 1, 8'hB0, 1, 0, 0));
    apply("mr_idle",  mk(32'h00000000, 4'b0000, 4'b0000, 0, 4'b0000, 0, 8'hB0, 0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter byte interface (tx_data / tx_valid / tx_ready) among NUM_REQ independent byte-stream requesters.
- Arbitration is round-robin at packet granularity. Once a requester is granted, it keeps the UART until it sends a byte flagged req_last, or until an inter-byte timeout expires.
- Sits between the firmware/debug byte sources and the UART TX serializer. Its tx_* outputs connect directly to the serializer's tx_data, tx_valid and tx_ready.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..16.
- TIMEOUT_CYCLES, 1024, clk cycles a granted requester may idle mid-packet before the grant is revoked; 0 disables the timeout.
- IDW, $clog2(NUM_REQ), width of the requester index (derived; do not override).

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_data  in  NUM_REQ*8  byte from requester i on bits [8i+7:8i].
- req_valid  in  NUM_REQ  requester i presents a byte.
- req_last  in  NUM_REQ  the byte presented by requester i ends its packet.
- req_ready  out  NUM_REQ  byte from requester i is accepted this cycle when req_valid[i] is also high.
- tx_data  out  8  byte to the UART serializer.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  serializer accepts the byte; a transfer occurs on tx_valid && tx_ready.
- grant_id  out  IDW  index of the current owner; meaningful only while busy=1.
- busy  out  1  a packet is in progress (state is not IDLE).
- timeout_err  out  1  one-cycle pulse when a grant is revoked by timeout.

Behaviour:
- Reset values: tx_valid=0, tx_data=0, grant_id=0, busy=0, timeout_err=0, rr_ptr=0, state=IDLE, timeout counter=0.
- req_ready is all-zero while rst_n=0 and for the first clk edge after release. This is gated by a registered run flag that is cleared by reset and set on the first clk edge.
- req_ready is combinational from state, rr_ptr, owner and req_valid. It is one-hot or zero; no more than one bit is ever high.
- States: IDLE, SEND, WAIT. Encoding is 2 bits.
- IDLE:
  - Winner is the first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... with wrap modulo NUM_REQ.
  - req_ready[winner]=1 in the same cycle.
  - On the next edge: tx_data<=byte, tx_valid<=1, owner<=winner, last_q<=req_last[winner]; go to SEND.
  - If no req_valid bit is set, stay in IDLE.
- SEND:
  - tx_valid=1; tx_data is held stable until the transfer. All req_ready bits are 0.
  - On transfer, tx_valid<=0. If last_q=1: rr_ptr<=owner+1 (mod NUM_REQ), go to IDLE. If last_q=0: clear the timeout counter and go to WAIT.
- WAIT:
  - req_ready[owner]=req_valid[owner]; all other bits are 0. Requests from non-owners are ignored.
  - On acceptance: load tx_data and last_q, set tx_valid<=1, go to SEND.
  - Otherwise the counter increments each cycle. When TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES-1 with no valid byte: timeout_err=1 for 1 cycle, rr_ptr<=owner+1, go to IDLE.
  - If the owner's valid arrives in the same cycle as the counter expiry, the byte is accepted and no timeout fires.
- Latency:
  - Requester acceptance to tx_valid high: 1 cycle.
  - Downstream transfer to the next req_ready from the same owner: 1 cycle (via WAIT).
- Throughput: at most one byte per 2 cycles. This is ample, since the serializer needs ≥10 bit-times per byte.
- busy=1 in SEND and WAIT. grant_id=owner register.
- The serializer drops tx_ready the cycle after accepting a byte. The arbiter must not rely on tx_ready staying high, and must never present tx_valid=1 with changing tx_data.
- rr_ptr wraps from NUM_REQ-1 to 0. When NUM_REQ is not a power of two, the increment must wrap explicitly, not rely on bit-width overflow.
- Asynchronous reset during SEND/WAIT aborts the packet immediately. All outputs return to their reset values, and no byte is re-sent after release.
- Counter width: $clog2(TIMEOUT_CYCLES+1), minimum 1 bit.

Decomposition:
- Package uart_arb_pkg holds the state localparams (ST_IDLE=2'd0, ST_SEND=2'd1, ST_WAIT=2'd2) and the function for the wrap-safe index increment.
- Sub-module uart_rr_pick: combinational rotating priority picker.
  - Inputs: req_valid[NUM_REQ], rr_ptr[IDW].
  - Outputs: any_valid, winner[IDW].
  - Implemented by doubling the request vector and masking.
- All state lives in uart_tx_arbiter.

Test Plan:
- Single request: req0 presents 0xA5 with last=1, tx_ready=1 → req_ready[0] in that cycle, tx_valid=1 / tx_data=0xA5 next cycle, busy=0 one cycle after the transfer, rr_ptr=1.
- Round-robin: req0 and req2 continuously present 1-byte packets (0x10, 0x20) → downstream sequence 0x10, 0x20, 0x10, 0x20; grant_id alternates 0, 2.
- Packet lock: req1 sends 0x11, 0x22, 0x33 (last on 0x33) while req0 is continuously valid → 0x11, 0x22, 0x33 are contiguous downstream before any req0 byte; req_ready[0]=0 throughout.
- Backpressure: tx_ready held low for 20 cycles with tx_valid=1, tx_data=0x5C → tx_data is stable, req_ready is all-zero, and a single transfer occurs when tx_ready rises.
- Timeout: TIMEOUT_CYCLES=16, req3 sends 0x77 with last=0 then drops valid → timeout_err pulses once, 16 cycles after entering WAIT; req0 (pending) is granted next; no pulse occurs when req3 revalidates exactly on the expiry cycle.
- Mid-packet reset: assert rst_n=0 during WAIT of a 3-byte packet → tx_valid=0, busy=0, req_ready=0 immediately; after release, the first grant goes to the lowest valid index, since rr_ptr=0.
